// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide RAM port controller: FSM states,
// MEM length codes, read/write codes and the enable/busy levels.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic BUSY    = 1'b1;

  // Byte count of a MEM access; code 3 behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between ICache fills and MEM
// loads/stores, sequencing each access as little-endian byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              ICacheE_in,
  input  logic [ADDR_W-1:0] ICacheAddr_in,
  input  logic              MEME_in,
  input  logic              MEMrw_in,
  input  logic [1:0]        MEMlen_in,
  input  logic [ADDR_W-1:0] MEMaddr_in,
  input  logic [31:0]       MEMdata_in,
  input  logic [7:0]        mem_din_in,
  output logic              ICache_instE_out,
  output logic [31:0]       ICache_inst_out,
  output logic              MEM_dataE_out,
  output logic [31:0]       MEM_data_out,
  output logic              busyICache_out,
  output logic              busyMEM_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout_out,
  output logic              mem_wr_out
);

  state_t            state_q, state_d;
  logic              owner_ic_q, owner_ic_d;
  logic              rw_q, rw_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        cap_q, cap_d;
  logic              pend_q, pend_d;
  logic              busy_ic_q, busy_ic_d;
  logic              busy_mem_q, busy_mem_d;
  logic              ic_abort;

  assign busyICache_out = busy_ic_q;
  assign busyMEM_out    = busy_mem_q;

  assign ic_abort = (state_q == XFER) && owner_ic_q &&
                    (!ICacheE_in || (ICacheAddr_in != addr_q));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      owner_ic_q <= 1'b0;
      rw_q       <= READ;
      nbytes_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      iss_q      <= 3'd0;
      cap_q      <= 3'd0;
      pend_q     <= 1'b0;
      busy_ic_q  <= DISABLE;
      busy_mem_q <= DISABLE;
    end else begin
      state_q    <= state_d;
      owner_ic_q <= owner_ic_d;
      rw_q       <= rw_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      pend_q     <= pend_d;
      busy_ic_q  <= busy_ic_d;
      busy_mem_q <= busy_mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_ic_d = owner_ic_q;
    rw_d       = rw_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    pend_d     = pend_q;
    busy_ic_d  = busy_ic_q;
    busy_mem_d = busy_mem_q;

    mem_a_out        = '0;
    mem_dout_out     = 8'd0;
    mem_wr_out       = DISABLE;
    ICache_instE_out = 1'b0;
    ICache_inst_out  = 32'd0;
    MEM_dataE_out    = 1'b0;
    MEM_data_out     = 32'd0;

    if (!rst_in) begin
      if (rdy_in) begin
        case (state_q)
          IDLE: begin
            iss_d   = 3'd0;
            cap_d   = 3'd0;
            pend_d  = 1'b0;
            rdata_d = 32'd0;
            if (MEME_in) begin
              state_d    = XFER;
              owner_ic_d = 1'b0;
              rw_d       = MEMrw_in;
              nbytes_d   = len_bytes(MEMlen_in);
              addr_d     = MEMaddr_in;
              wdata_d    = MEMdata_in;
              busy_mem_d = BUSY;
            end else if (ICacheE_in) begin
              state_d    = XFER;
              owner_ic_d = 1'b1;
              rw_d       = READ;
              nbytes_d   = 3'd4;
              addr_d     = ICacheAddr_in;
              wdata_d    = 32'd0;
              busy_ic_d  = BUSY;
            end
          end

          XFER: begin
            if (ic_abort) begin
              state_d   = IDLE;
              busy_ic_d = DISABLE;
              iss_d     = 3'd0;
              cap_d     = 3'd0;
              pend_d    = 1'b0;
            end else begin
              // The byte issued last cycle is on mem_din_in now.
              if (pend_q) begin
                rdata_d[{cap_q[1:0], 3'b000} +: 8] = mem_din_in;
                cap_d = cap_q + 3'd1;
              end
              pend_d = 1'b0;
              if (iss_q < nbytes_q) begin
                mem_a_out = addr_q + ADDR_W'(iss_q);
                iss_d     = iss_q + 3'd1;
                if (rw_q == WRITE) begin
                  mem_wr_out   = ENABLE;
                  mem_dout_out = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                  cap_d        = iss_q + 3'd1;
                end else begin
                  pend_d = 1'b1;
                end
              end
              if ((rw_q == WRITE) ? (iss_q == nbytes_q - 3'd1)
                                  : (pend_q && (cap_q == nbytes_q - 3'd1))) begin
                state_d    = DONE;
                busy_ic_d  = DISABLE;
                busy_mem_d = DISABLE;
                iss_d      = 3'd0;
                cap_d      = 3'd0;
                pend_d     = 1'b0;
              end
            end
          end

          DONE: begin
            state_d = IDLE;
            if (owner_ic_q) begin
              ICache_instE_out = 1'b1;
              ICache_inst_out  = rdata_q;
            end else begin
              MEM_dataE_out = 1'b1;
              MEM_data_out  = rdata_q;
            end
          end

          default: state_d = IDLE;
        endcase
      end else if (state_q == XFER) begin
        // Stall: rewind to the first uncaptured byte and reissue it on resume.
        mem_a_out = addr_q + ADDR_W'(cap_q);
        iss_d     = cap_q;
        pend_d    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model answers the port one cycle
// late, and each scenario checks per-cycle traces plus completion pulses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, ic_e, mem_e, mem_rw;
  logic [31:0] ic_addr, mem_addr, mem_data;
  logic [1:0]  mem_len;
  logic [7:0]  din;
  logic        ic_done, mem_done, busy_ic, busy_mem, wr;
  logic [31:0] ic_inst, mem_rdata, addr_o;
  logic [7:0]  dout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_ic;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [7:0]  ram [0:262143];
  logic        rdy_pat [32];
  logic [31:0] tr_a [32];
  logic [7:0]  tr_dout [32];
  logic        tr_wr [32];
  logic        tr_ice [32];
  logic        tr_me [32];
  logic [31:0] tr_icd [32];
  logic [31:0] tr_md [32];
  logic        tr_bic [32];
  logic        tr_bm [32];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .ICacheE_in(ic_e), .ICacheAddr_in(ic_addr),
    .MEME_in(mem_e), .MEMrw_in(mem_rw), .MEMlen_in(mem_len),
    .MEMaddr_in(mem_addr), .MEMdata_in(mem_data), .mem_din_in(din),
    .ICache_instE_out(ic_done), .ICache_inst_out(ic_inst),
    .MEM_dataE_out(mem_done), .MEM_data_out(mem_rdata),
    .busyICache_out(busy_ic), .busyMEM_out(busy_mem),
    .mem_a_out(addr_o), .mem_dout_out(dout), .mem_wr_out(wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    din <= ram[addr_o[17:0]];
    if (wr) ram[addr_o[17:0]] <= dout;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_trace();
    for (int i = 0; i < 32; i++) begin
      rdy_pat[i] = 1'b1;
      tr_a[i] = '0; tr_dout[i] = '0; tr_wr[i] = 0; tr_ice[i] = 0; tr_me[i] = 0;
      tr_icd[i] = '0; tr_md[i] = '0; tr_bic[i] = 0; tr_bm[i] = 0;
    end
  endtask

  // Steps cycles first..last, recording outputs; requesters drop on their pulse.
  task automatic run(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rdy = rdy_pat[i];
      #1;
      tr_a[i] = addr_o; tr_dout[i] = dout; tr_wr[i] = wr;
      tr_ice[i] = ic_done; tr_me[i] = mem_done;
      tr_icd[i] = ic_inst; tr_md[i] = mem_rdata;
      tr_bic[i] = busy_ic; tr_bm[i] = busy_mem;
      if (ic_done) ic_e = 1'b0;
      if (mem_done) mem_e = 1'b0;
      @(posedge clk); #1;
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; ic_e = 0; mem_e = 0; mem_rw = 0; mem_len = 0;
    ic_addr = '0; mem_addr = '0; mem_data = '0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({ic_done, ic_inst, mem_done, mem_rdata, busy_ic, busy_mem, addr_o, dout, wr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ic=%b/%h mem=%b/%h busy=%b%b a=%h d=%h wr=%b want all zero",
               ic_done, ic_inst, mem_done, mem_rdata, busy_ic, busy_mem, addr_o, dout, wr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    clear_trace();
    ic_e = 1'b1; ic_addr = 32'h104;
    sb.push_back('{1'b1, 32'h0000_0513, 6});
    run(0, 9);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (tr_a[c] !== 32'h104 + 32'(c - 1)) begin
        n_fail++; $display("FAIL fetch_addr cycle=%0d got %h want %h", c, tr_a[c], 32'h104 + 32'(c - 1));
      end
    end
    for (int c = 0; c <= 9; c++) begin
      n_tests++;
      if ({tr_bic[c], tr_wr[c]} !== {(c >= 1 && c <= 5), 1'b0}) begin
        n_fail++; $display("FAIL fetch_busy_wr cycle=%0d got busy=%b wr=%b want busy=%b wr=0", c, tr_bic[c], tr_wr[c], (c >= 1 && c <= 5));
      end
    end
    n_tests++;
    if ({tr_a[0], tr_a[5], tr_a[6]} !== 96'd0) begin
      n_fail++; $display("FAIL fetch_no_extra_addr got %h %h %h want 0", tr_a[0], tr_a[5], tr_a[6]);
    end
    for (int c = 0; c <= 9; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL fetch_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL fetch_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL fetch_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_store();
    logic [31:0] word;
    logic [7:0]  exp_b [4];
    clear_trace();
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    mem_e = 1'b1; mem_rw = 1'b1; mem_len = 2'd2; mem_addr = 32'h200; mem_data = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 32'd0, 5});
    run(0, 7);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if ({tr_wr[c], tr_a[c], tr_dout[c], tr_bm[c]} !== {1'b1, 32'h200 + 32'(c - 1), exp_b[c - 1], 1'b1}) begin
        n_fail++; $display("FAIL store_byte cycle=%0d got wr=%b a=%h d=%h busy=%b want wr=1 a=%h d=%h busy=1", c, tr_wr[c], tr_a[c], tr_dout[c], tr_bm[c], 32'h200 + 32'(c - 1), exp_b[c - 1]);
      end
    end
    n_tests++;
    if ({tr_wr[0], tr_wr[5], tr_wr[6], tr_wr[7], tr_bm[5]} !== 5'd0) begin
      n_fail++; $display("FAIL store_idle_wr got %b%b%b%b busy5=%b want 0", tr_wr[0], tr_wr[5], tr_wr[6], tr_wr[7], tr_bm[5]);
    end
    word = {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]};
    n_tests++;
    if (word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_ram got %h want deadbeef", word); end
    for (int c = 0; c <= 7; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL store_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL store_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL store_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_byte_load();
    int hits;
    clear_trace();
    mem_e = 1'b1; mem_rw = 1'b0; mem_len = 2'd0; mem_addr = 32'h0003_0000;
    sb.push_back('{1'b0, 32'h0000_0041, 3});
    run(0, 5);
    hits = 0;
    for (int c = 0; c <= 5; c++) if (tr_a[c] == 32'h0003_0000) hits++;
    n_tests++;
    if ({hits, tr_a[1]} !== {32'd1, 32'h0003_0000}) begin
      n_fail++; $display("FAIL byte_load_single_read got hits=%0d a1=%h want hits=1 a1=00030000", hits, tr_a[1]);
    end
    for (int c = 0; c <= 5; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL byte_load_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL byte_load_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL byte_load_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    clear_trace();
    mem_e = 1'b1; mem_rw = 1'b0; mem_len = 2'd1; mem_addr = 32'h10;
    ic_e = 1'b1; ic_addr = 32'h104;
    sb.push_back('{1'b0, 32'h0000_1234, 4});
    sb.push_back('{1'b1, 32'h0000_0513, 11});
    run(0, 14);
    n_tests++;
    if ({tr_a[1], tr_a[2], tr_bm[1], tr_bic[1]} !== {32'h10, 32'h11, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL arb_mem_first got a1=%h a2=%h bm=%b bic=%b want 10 11 1 0", tr_a[1], tr_a[2], tr_bm[1], tr_bic[1]);
    end
    n_tests++;
    if ({tr_bic[5], tr_bic[6], tr_a[3], tr_a[6], tr_a[9]} !== {1'b0, 1'b1, 32'h0, 32'h104, 32'h107}) begin
      n_fail++; $display("FAIL arb_icache_after got bic5=%b bic6=%b a3=%h a6=%h a9=%h want 0 1 0 104 107", tr_bic[5], tr_bic[6], tr_a[3], tr_a[6], tr_a[9]);
    end
    for (int c = 0; c <= 14; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL arb_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL arb_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL arb_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_abort();
    clear_trace();
    ic_e = 1'b1; ic_addr = 32'h104;
    run(0, 1);
    ic_addr = 32'h300;
    sb.push_back('{1'b1, 32'h0123_4567, 9});
    run(2, 12);
    n_tests++;
    if ({tr_a[1], tr_bic[2], tr_bic[3], tr_bic[4]} !== {32'h104, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL abort_busy got a1=%h bic2=%b bic3=%b bic4=%b want 104 1 0 1", tr_a[1], tr_bic[2], tr_bic[3], tr_bic[4]);
    end
    for (int c = 4; c <= 7; c++) begin
      n_tests++;
      if (tr_a[c] !== 32'h300 + 32'(c - 4)) begin
        n_fail++; $display("FAIL abort_refetch_addr cycle=%0d got %h want %h", c, tr_a[c], 32'h300 + 32'(c - 4));
      end
    end
    for (int c = 0; c <= 12; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL abort_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL abort_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL abort_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stall();
    clear_trace();
    rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b0;
    mem_e = 1'b1; mem_rw = 1'b0; mem_len = 2'd2; mem_addr = 32'h40;
    sb.push_back('{1'b0, 32'h4433_2211, 10});
    run(0, 12);
    for (int c = 3; c <= 8; c++) begin
      n_tests++;
      if ({tr_a[c], tr_wr[c]} !== {((c <= 6) ? 32'h41 : 32'h40 + 32'(c - 5)), 1'b0}) begin
        n_fail++; $display("FAIL stall_addr cycle=%0d got a=%h wr=%b want a=%h wr=0", c, tr_a[c], tr_wr[c], ((c <= 6) ? 32'h41 : 32'h40 + 32'(c - 5)));
      end
    end
    n_tests++;
    if ({tr_bm[9], tr_bm[10], tr_a[9]} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL stall_busy got bm9=%b bm10=%b a9=%h want 1 0 0", tr_bm[9], tr_bm[10], tr_a[9]);
    end
    for (int c = 0; c <= 12; c++) if (tr_ice[c] || tr_me[c]) begin
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL stall_unexpected_pulse cycle=%0d", c); end
      else begin
        e = sb.pop_front();
        if ({tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c} !== {e.is_ic, e.data, e.cyc}) begin
          n_fail++; $display("FAIL stall_pulse got ic=%b data=%h cyc=%0d want ic=%b data=%h cyc=%0d", tr_ice[c], (tr_ice[c] ? tr_icd[c] : tr_md[c]), c, e.is_ic, e.data, e.cyc);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL stall_missing_pulse got %0d left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_trace();
    mem_e = 1'b1; mem_rw = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_data = 32'hCAFE_F00D;
    run(0, 1);
    rst = 1'b1; mem_e = 1'b0;
    run(2, 2);
    rst = 1'b0;
    run(3, 8);
    bad = 0;
    for (int c = 3; c <= 8; c++)
      if ({tr_a[c], tr_dout[c], tr_wr[c], tr_ice[c], tr_me[c], tr_icd[c], tr_md[c], tr_bic[c], tr_bm[c]} != '0) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_outputs got %0d nonzero cycles want 0", bad); end
    n_tests++;
    if ({ram[18'h500], ram[18'h501]} !== {8'h0D, 8'h00}) begin
      n_fail++; $display("FAIL reset_mid_ram got %h %h want 0d 00", ram[18'h500], ram[18'h501]);
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h104] = 8'h13; ram[18'h105] = 8'h05; ram[18'h106] = 8'h00; ram[18'h107] = 8'h00;
    ram[18'h30000] = 8'h41;
    ram[18'h10] = 8'h34; ram[18'h11] = 8'h12;
    ram[18'h300] = 8'h67; ram[18'h301] = 8'h45; ram[18'h302] = 8'h23; ram[18'h303] = 8'h01;
    ram[18'h40] = 8'h11; ram[18'h41] = 8'h22; ram[18'h42] = 8'h33; ram[18'h43] = 8'h44;

    test_reset();
    test_fetch();
    test_store();
    test_byte_load();
    test_back_to_back();
    test_abort();
    test_stall();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
